bcd_digit_encoder: RTL and testbench

BCD_DIGIT_ENCODER -- requirements
Module: bcd_digit_encoder

---
 rtl/bcd_digit_encoder.sv | 147 ++++++++++++++
 tb/tb_bcd_digit_encoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_encoder.sv
// bcd_digit_encoder: converts five BCD digits to a 16-bit binary value using
// reverse double-dabble (shift right, subtract 3 from digits >= 8), one step
// per cycle, 16 steps per request.
// Optional feature: define BCD_OVERFLOW_CHECK_EN to enable the overflow and
// bad_digit detection. Without it both flags are constant 0.
module bcd_digit_encoder #(
  parameter int unsigned ITERATIONS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            tenthousands,
  input  logic [3:0]            thousands,
  input  logic [3:0]            hundreds,
  input  logic [3:0]            tens,
  input  logic [3:0]            ones,
  output logic [ITERATIONS-1:0] binary,
  output logic                  out_valid,
  output logic                  overflow,
  output logic                  bad_digit
);

  localparam int unsigned DIGITS = 5;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(ITERATIONS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [ITERATIONS-1:0] bin_q, bin_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ITERATIONS-1:0] binary_q, binary_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;

  logic [BCD_W-1:0]      bcd_sh;
  logic [ITERATIONS-1:0] bin_sh;
  logic [BCD_W-1:0]      bcd_fix;

`ifdef BCD_OVERFLOW_CHECK_EN
  logic overflow_q, overflow_d;
  logic bad_digit_q, bad_digit_d;
  logic bad_lat_q, bad_lat_d;
`endif

  // Next-state, datapath step and output computation
  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    cnt_d       = cnt_q;
    binary_d    = binary_q;
    out_valid_d = 1'b0;
`ifdef BCD_OVERFLOW_CHECK_EN
    overflow_d  = overflow_q;
    bad_digit_d = bad_digit_q;
    bad_lat_d   = bad_lat_q;
`endif

    // One reverse double-dabble step on the concatenated {bcd, bin}
    {bcd_sh, bin_sh} = {1'b0, bcd_q, bin_q[ITERATIONS-1:1]};
    bcd_fix = bcd_sh;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd8) begin
        bcd_fix[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          bcd_d   = {tenthousands, thousands, hundreds, tens, ones};
          bin_d   = '0;
          cnt_d   = '0;
`ifdef BCD_OVERFLOW_CHECK_EN
          bad_lat_d = (tenthousands > 4'd9) || (thousands > 4'd9) ||
                      (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
`endif
        end
      end
      SHIFT: begin
        bcd_d = bcd_fix;
        bin_d = bin_sh;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
          state_d     = DONE;
          binary_d    = bin_sh;
          out_valid_d = 1'b1;
`ifdef BCD_OVERFLOW_CHECK_EN
          overflow_d  = |bcd_fix;
          bad_digit_d = bad_lat_q;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      binary_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef BCD_OVERFLOW_CHECK_EN
      overflow_q  <= 1'b0;
      bad_digit_q <= 1'b0;
      bad_lat_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      cnt_q       <= cnt_d;
      binary_q    <= binary_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef BCD_OVERFLOW_CHECK_EN
      overflow_q  <= overflow_d;
      bad_digit_q <= bad_digit_d;
      bad_lat_q   <= bad_lat_d;
`endif
    end
  end

  assign binary    = binary_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
`ifdef BCD_OVERFLOW_CHECK_EN
  assign overflow  = overflow_q;
  assign bad_digit = bad_digit_q;
`else
  assign overflow  = 1'b0;
  assign bad_digit = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_digit_encoder.sv
// Self-checking bench for bcd_digit_encoder: table of directed conversions
// plus hand-written sequences for continuous requests and reset corner cases.
// Expected flag values follow BCD_OVERFLOW_CHECK_EN when it is defined.
module tb_bcd_digit_encoder;

`ifdef BCD_OVERFLOW_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  tenthousands = '0, thousands = '0, hundreds = '0, tens = '0, ones = '0;
  logic [15:0] binary;
  logic        out_valid, overflow, bad_digit;

  int total = 0;
  int bad = 0;

  bcd_digit_encoder #(.ITERATIONS(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .tenthousands(tenthousands), .thousands(thousands), .hundreds(hundreds),
    .tens(tens), .ones(ones), .binary(binary), .out_valid(out_valid),
    .overflow(overflow), .bad_digit(bad_digit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] dig;
    logic [15:0] bin;
    logic        chk_bin;
    logic        ov;
    logic        bd;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    r[19:16] = 4'((v / 10000) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic set_digits(input logic [19:0] d);
    {tenthousands, thousands, hundreds, tens, ones} = d;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // One request: checks latency, single-cycle pulse, result, flags and hold
  task automatic run_conv(input vec_t v, input string nm);
    int lat;
    logic [15:0] held;
    wait_ready();
    @(negedge clk);
    set_digits(v.dig);
    in_valid = 1'b1;
    @(posedge clk); #1;           // E0
    in_valid = 1'b0;
    chk({nm, "_ready_low"}, 32'(in_ready), 32'd0);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'd16);
    if (v.chk_bin) begin
      chk({nm, "_binary"}, 32'(binary), 32'(v.bin));
      chk({nm, "_overflow"}, 32'(overflow), 32'(OVF_EN & v.ov));
    end
    chk({nm, "_bad_digit"}, 32'(bad_digit), 32'(OVF_EN & v.bd));
    held = binary;
    @(posedge clk); #1;           // E17
    chk({nm, "_pulse_end"}, 32'(out_valid), 32'd0);
    chk({nm, "_ready_back"}, 32'(in_ready), 32'd1);
    chk({nm, "_hold"}, 32'(binary), 32'(held));
  endtask

  initial begin
    vecs[0]  = '{20'h12345, 16'h3039, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{20'h65535, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{20'h65536, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{20'h99999, 16'h869F, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{20'h000A0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{20'h00000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{20'h00001, 16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{20'h42000, 16'hA410, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{20'h10000, 16'h2710, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{20'h70000, 16'h1170, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{20'h00255, 16'h00FF, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_binary", 32'(binary), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_bad_digit", 32'(bad_digit), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_conv(vecs[i], $sformatf("vec%0d", i));

    // in_valid held high with digits changing every cycle
    begin
      logic [15:0] expq[$];
      int last_pulse = -1;
      int pulses = 0;
      int last_acc = -1;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        set_digits(to_bcd((k * 1237 + 11) % 60000));
        in_valid = 1'b1;
        if (in_ready) begin
          expq.push_back(16'((k * 1237 + 11) % 60000));
          if (last_acc >= 0) chk("cont_accept_spacing", 32'(k - last_acc), 32'd18);
          last_acc = k;
        end
        @(posedge clk); #1;
        if (out_valid) begin
          pulses++;
          if (last_pulse >= 0) chk("cont_pulse_spacing", 32'(k - last_pulse), 32'd18);
          last_pulse = k;
          if (expq.size() == 0) chk("cont_unexpected_pulse", 32'd1, 32'd0);
          else chk("cont_binary", 32'(binary), 32'(expq.pop_front()));
        end
      end
      in_valid = 1'b0;
      for (int k = 0; k < 20 && expq.size() > 0; k++) begin
        @(posedge clk); #1;
        if (out_valid) chk("cont_drain_binary", 32'(binary), 32'(expq.pop_front()));
      end
      chk("cont_queue_empty", 32'(expq.size()), 32'd0);
      chk("cont_pulses", 32'(pulses), 32'd3);
    end

    // Reset at E8 aborts the conversion
    begin
      int seen = 0;
      wait_ready();
      @(negedge clk);
      set_digits(20'h12345);
      in_valid = 1'b1;
      @(posedge clk); #1;         // E0
      in_valid = 1'b0;
      repeat (7) @(posedge clk);  // E1..E7
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;         // E8
      reset = 1'b0;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_binary", 32'(binary), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("abort_no_pulse", 32'(seen), 32'd0);
      run_conv(vecs[7], "after_abort");
    end

    // Reset and in_valid on the same edge: request dropped
    begin
      int seen = 0;
      @(negedge clk);
      set_digits(20'h00777);
      reset = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      in_valid = 1'b0;
      chk("rst_prio_in_ready", 32'(in_ready), 32'd1);
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("rst_prio_no_pulse", 32'(seen), 32'd0);
      run_conv(vecs[0], "after_prio");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
